// File: rtl/pipeline_stage_3_ex.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipeline_stage_3_ex
// Execute stage of the 5-stage MIPS pipeline. It holds the ALU, the flag
// generator, the branch/jump target adders and an iterative multiply/divide
// unit (MDU) that owns the HI/LO registers. It also loads the EX/MEM register.
//
// Optional build macro: EX_FAST_MUL_EN
//   defined   -> MULT/MULTU finish in one cycle through a combinational
//                multiplier. DIV/DIVU stay iterative.
//   undefined -> all four MDU ops run on the iterative state machine.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             next EX/MEM load is a bubble (M/WB cleared); aborts MDU
//   IDEX_*            ID/EX pipeline register contents (operands, controls)
//   EXMEM_*           registered EX/MEM pipeline register fields
//   stall             high while the MDU is in flight (upstream must hold)
//
// The MDU produces one product/quotient bit per cycle. MD_CYCLES must
// therefore stay at 32 for the results to be arithmetically correct.
// -----------------------------------------------------------------------------
module pipeline_stage_3_ex #(
    parameter int          MD_CYCLES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] IDEX_PC,
    input  logic [15:0] IDEX_M,
    input  logic [3:0]  IDEX_WB,
    input  logic [4:0]  IDEX_ALUop,
    input  logic        IDEX_ALUsrc,
    input  logic [31:0] IDEX_RS,
    input  logic [31:0] IDEX_RT,
    input  logic [31:0] IDEX_Imm,
    input  logic [4:0]  IDEX_Shamt,
    input  logic [25:0] IDEX_Jfield,
    input  logic [4:0]  IDEX_Waddr,
    output logic [15:0] EXMEM_M,
    output logic [3:0]  EXMEM_WB,
    output logic [31:0] EXMEM_Baddr,
    output logic [31:0] EXMEM_Jaddr,
    output logic [3:0]  EXMEM_FLAGS,
    output logic [31:0] EXMEM_ALU,
    output logic [31:0] EXMEM_MData,
    output logic [4:0]  EXMEM_Waddr,
    output logic [31:0] EXMEM_PC,
    output logic        stall
);
    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
    localparam logic [4:0] OP_MFHI = 5'd12, OP_MFLO = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU = 5'd17, OP_MTHI = 5'd18, OP_MTLO = 5'd19;

    typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of a value when it is treated as signed; raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    md_state_t         md_state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              md_div_r, neg_res_r, neg_rem_r, div_zero_r;
    logic [31:0]       acc_hi_r, acc_lo_r, mag_b_r, dividend_r;
    logic [31:0]       hi_r, lo_r;

    logic [31:0] op_b_s, alu_res_s;
    logic [32:0] sum_s, diff_s;
    logic        flag_c_s, flag_v_s;
    logic        is_md_s, op_signed_s, op_div_s, md_start_s, stall_s, bubble_s, mt_ok_s;
    logic [32:0] mul_sum_s, div_trial_s;
    logic        div_ge_s;
    logic [31:0] div_rem_s, md_hi_s, md_lo_s;
    logic [63:0] prod_s;

    assign op_b_s      = IDEX_ALUsrc ? IDEX_Imm : IDEX_RT;
    assign op_signed_s = (IDEX_ALUop == OP_MULT) || (IDEX_ALUop == OP_DIV);
    assign op_div_s    = (IDEX_ALUop == OP_DIV) || (IDEX_ALUop == OP_DIVU);
`ifdef EX_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    logic        fast_mul_wr_s;
    // Sign/zero-extend to 64 bits so the low 64 bits of the product are exact.
    assign fast_prod_s   = (IDEX_ALUop == OP_MULT) ?
                           ({{32{IDEX_RS[31]}}, IDEX_RS} * {{32{op_b_s[31]}}, op_b_s}) :
                           ({32'd0, IDEX_RS} * {32'd0, op_b_s});
    assign fast_mul_wr_s = (md_state_r == MD_IDLE) && !flush &&
                           ((IDEX_ALUop == OP_MULT) || (IDEX_ALUop == OP_MULTU));
    assign is_md_s       = op_div_s;
`else
    assign is_md_s       = op_div_s || (IDEX_ALUop == OP_MULT) || (IDEX_ALUop == OP_MULTU);
`endif
    // stall rises combinationally in the accepting cycle so ID/EX holds at once.
    assign md_start_s = !rst && (md_state_r == MD_IDLE) && !flush && is_md_s;
    assign stall_s    = md_start_s || (!rst && (md_state_r == MD_BUSY));
    assign stall      = stall_s;
    assign bubble_s   = flush || stall_s;
    assign mt_ok_s    = (md_state_r == MD_IDLE) && !flush;

    // ALU datapath and V/C flag generation.
    always_comb begin
        sum_s     = {1'b0, IDEX_RS} + {1'b0, op_b_s};
        diff_s    = {1'b0, IDEX_RS} + {1'b0, ~op_b_s} + 33'd1;  // carry = no-borrow
        alu_res_s = 32'd0;
        flag_c_s  = 1'b0;
        flag_v_s  = 1'b0;
        case (IDEX_ALUop)
            OP_ADD: begin
                alu_res_s = sum_s[31:0];
                flag_c_s  = sum_s[32];
                flag_v_s  = (IDEX_RS[31] == op_b_s[31]) && (sum_s[31] != IDEX_RS[31]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[31:0];
                flag_c_s  = diff_s[32];
                flag_v_s  = (IDEX_RS[31] != op_b_s[31]) && (diff_s[31] != IDEX_RS[31]);
            end
            OP_AND:  alu_res_s = IDEX_RS & op_b_s;
            OP_OR:   alu_res_s = IDEX_RS | op_b_s;
            OP_XOR:  alu_res_s = IDEX_RS ^ op_b_s;
            OP_NOR:  alu_res_s = ~(IDEX_RS | op_b_s);
            OP_SLT:  alu_res_s = {31'd0, ($signed(IDEX_RS) < $signed(op_b_s))};
            OP_SLTU: alu_res_s = {31'd0, (IDEX_RS < op_b_s)};
            OP_SLL:  alu_res_s = op_b_s << IDEX_Shamt;
            OP_SRL:  alu_res_s = op_b_s >> IDEX_Shamt;
            OP_SRA:  alu_res_s = $unsigned($signed(op_b_s) >>> IDEX_Shamt);
            OP_LUI:  alu_res_s = {op_b_s[15:0], 16'd0};
            OP_MFHI: alu_res_s = hi_r;
            OP_MFLO: alu_res_s = lo_r;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: alu_res_s = 32'd0;
            default: alu_res_s = op_b_s;
        endcase
    end

    // MDU step logic (shift-add / restoring divide) and final sign fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mag_b_r} : 33'd0);
        div_trial_s = {acc_hi_r, acc_lo_r[31]};
        div_ge_s    = (div_trial_s >= {1'b0, mag_b_r});
        // The difference is below the divisor, so 32 bits hold it exactly.
        div_rem_s   = div_ge_s ? (div_trial_s[31:0] - mag_b_r) : div_trial_s[31:0];
        prod_s      = neg_res_r ? (~{acc_hi_r, acc_lo_r} + 64'd1) : {acc_hi_r, acc_lo_r};
        if (md_div_r) begin
            if (div_zero_r) begin
                md_hi_s = dividend_r;
                md_lo_s = 32'hFFFF_FFFF;
            end else begin
                md_hi_s = neg_rem_r ? neg32(acc_hi_r) : acc_hi_r;
                md_lo_s = neg_res_r ? neg32(acc_lo_r) : acc_lo_r;
            end
        end else begin
            md_hi_s = prod_s[63:32];
            md_lo_s = prod_s[31:0];
        end
    end

    // MDU state machine: operand capture, iteration, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state_r <= MD_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            md_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            acc_hi_r   <= 32'd0;
            acc_lo_r   <= 32'd0;
            mag_b_r    <= 32'd0;
            dividend_r <= 32'd0;
        end else begin
            case (md_state_r)
                MD_IDLE: begin
                    if (md_start_s) begin
                        md_state_r <= MD_BUSY;
                        cnt_r      <= CNT_W'(MD_CYCLES);
                        md_div_r   <= op_div_s;
                        neg_res_r  <= op_signed_s && (IDEX_RS[31] ^ op_b_s[31]);
                        neg_rem_r  <= op_signed_s && IDEX_RS[31];
                        div_zero_r <= (op_b_s == 32'd0);
                        dividend_r <= IDEX_RS;
                        acc_hi_r   <= 32'd0;
                        acc_lo_r   <= mag32(IDEX_RS, op_signed_s);
                        mag_b_r    <= mag32(op_b_s, op_signed_s);
                    end else begin
                        md_state_r <= MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        md_state_r <= MD_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (md_div_r) begin
                            acc_hi_r <= div_rem_s;
                            acc_lo_r <= {acc_lo_r[30:0], div_ge_s};
                        end else begin
                            acc_hi_r <= mul_sum_s[32:1];
                            acc_lo_r <= {mul_sum_s[0], acc_lo_r[31:1]};
                        end
                        md_state_r <= (cnt_r == CNT_W'(1)) ? MD_DONE : MD_BUSY;
                    end
                end
                MD_DONE: md_state_r <= MD_IDLE;
                default: md_state_r <= MD_IDLE;
            endcase
        end
    end

    // HI/LO registers: MDU completion, fast multiply and MTHI/MTLO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if ((md_state_r == MD_DONE) && !flush) begin
            hi_r <= md_hi_s;
            lo_r <= md_lo_s;
`ifdef EX_FAST_MUL_EN
        end else if (fast_mul_wr_s) begin
            hi_r <= fast_prod_s[63:32];
            lo_r <= fast_prod_s[31:0];
`endif
        end else if (mt_ok_s && (IDEX_ALUop == OP_MTHI)) begin
            hi_r <= IDEX_RS;
        end else if (mt_ok_s && (IDEX_ALUop == OP_MTLO)) begin
            lo_r <= IDEX_RS;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // EX/MEM pipeline register; flush or stall only clears the control bundles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXMEM_M     <= 16'd0;
            EXMEM_WB    <= 4'd0;
            EXMEM_Baddr <= 32'd0;
            EXMEM_Jaddr <= 32'd0;
            EXMEM_FLAGS <= 4'd0;
            EXMEM_ALU   <= 32'd0;
            EXMEM_MData <= 32'd0;
            EXMEM_Waddr <= 5'd0;
            EXMEM_PC    <= RESET_PC;
        end else begin
            EXMEM_M     <= bubble_s ? 16'd0 : IDEX_M;
            EXMEM_WB    <= bubble_s ? 4'd0 : IDEX_WB;
            EXMEM_Baddr <= IDEX_PC + (IDEX_Imm << 2);
            EXMEM_Jaddr <= {IDEX_PC[31:28], IDEX_Jfield, 2'b00};
            EXMEM_FLAGS <= {flag_v_s, flag_c_s, alu_res_s[31], (alu_res_s == 32'd0)};
            EXMEM_ALU   <= alu_res_s;
            EXMEM_MData <= IDEX_RT;
            EXMEM_Waddr <= IDEX_Waddr;
            EXMEM_PC    <= IDEX_PC;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_3_ex.sv
`timescale 1ns/1ps
// Self-checking bench for pipeline_stage_3_ex. Expected EX/MEM contents are
// pushed to a scoreboard queue when an instruction is driven and popped when
// the DUT loads EX/MEM.
module tb_pipeline_stage_3_ex;
    localparam logic [31:0] RST_PC = 32'h0000_0400;
    localparam int MD_CYC = 32;
`ifdef EX_FAST_MUL_EN
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_STALL = MD_CYC + 1;
`endif
    localparam int DIV_STALL = MD_CYC + 1;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_MFHI = 5'd12, OP_MFLO = 5'd13;
    localparam logic [4:0] OP_MULT = 5'd14, OP_DIV = 5'd16, OP_DIVU = 5'd17;
    localparam logic [4:0] OP_MTHI = 5'd18, OP_MTLO = 5'd19;

    typedef struct packed {
        logic [31:0] alu;
        logic [3:0]  flags;
        logic [15:0] m;
        logic [3:0]  wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, idex_alusrc;
    logic [31:0] idex_pc, idex_rs, idex_rt, idex_imm;
    logic [15:0] idex_m;
    logic [3:0]  idex_wb;
    logic [4:0]  idex_aluop, idex_shamt, idex_waddr;
    logic [25:0] idex_jfield;
    logic [15:0] exmem_m;
    logic [3:0]  exmem_wb, exmem_flags;
    logic [31:0] exmem_baddr, exmem_jaddr, exmem_alu, exmem_mdata, exmem_pc;
    logic [4:0]  exmem_waddr;
    logic        stall;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_stage_3_ex #(.MD_CYCLES(MD_CYC), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .IDEX_PC(idex_pc), .IDEX_M(idex_m), .IDEX_WB(idex_wb), .IDEX_ALUop(idex_aluop),
        .IDEX_ALUsrc(idex_alusrc), .IDEX_RS(idex_rs), .IDEX_RT(idex_rt), .IDEX_Imm(idex_imm),
        .IDEX_Shamt(idex_shamt), .IDEX_Jfield(idex_jfield), .IDEX_Waddr(idex_waddr),
        .EXMEM_M(exmem_m), .EXMEM_WB(exmem_wb), .EXMEM_Baddr(exmem_baddr),
        .EXMEM_Jaddr(exmem_jaddr), .EXMEM_FLAGS(exmem_flags), .EXMEM_ALU(exmem_alu),
        .EXMEM_MData(exmem_mdata), .EXMEM_Waddr(exmem_waddr), .EXMEM_PC(exmem_pc),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] m, input logic [3:0] wb);
        idex_aluop = op; idex_rs = a; idex_rt = b; idex_alusrc = 1'b0;
        idex_m = m; idex_wb = wb;
    endtask

    // Reference model for the single-cycle ALU ops, written from arithmetic
    // definitions: overflow is "true 64-bit result differs from 32-bit result".
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   input logic [15:0] m, input logic [3:0] wb);
        exp_t e; longint sa, sb, sr; logic [63:0] ur; logic [31:0] r; logic v, c;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        v = 1'b0; c = 1'b0; r = 32'd0;
        case (op)
            5'd0: begin ur = {32'd0, a} + {32'd0, b}; r = ur[31:0]; c = ur[32];
                        sr = sa + sb; v = (sr != longint'($signed(r))); end
            5'd1: begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr != longint'($signed(r))); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd7: r = (a < b) ? 32'd1 : 32'd0;
            5'd8: r = b << sh;
            5'd9: r = b >> sh;
            5'd10: begin sr = sb >>> sh; r = sr[31:0]; end
            5'd11: r = b * 32'd65536;
            default: r = b;
        endcase
        e.alu = r; e.flags = {v, c, r[31], (r == 32'd0)}; e.m = m; e.wb = wb;
        return e;
    endfunction

    task automatic test_reset;
        #12;
        n_checks++; if (exmem_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", exmem_pc, RST_PC); end
        n_checks++; if (exmem_alu !== 32'd0) begin n_fail++; $display("FAIL reset_alu: got %h expected 0", exmem_alu); end
        n_checks++; if ({exmem_m, exmem_wb, exmem_flags} !== 24'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", {exmem_m, exmem_wb, exmem_flags}); end
        n_checks++; if ({exmem_baddr, exmem_jaddr, exmem_mdata, exmem_waddr} !== 101'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {exmem_baddr, exmem_jaddr, exmem_mdata, exmem_waddr}); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow;
        exp_t e;
        set_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 4'hA);
        idex_pc = 32'h2000_0010; idex_jfield = 26'h0ABCDEF; idex_waddr = 5'd9; idex_imm = 32'h10;
        sb_q.push_back('{32'h8000_0000, 4'b1010, 16'h0000, 4'hA});
        step;
        e = sb_q.pop_front();
        n_checks++; if (exmem_alu !== e.alu) begin n_fail++; $display("FAIL add_alu: got %h expected %h", exmem_alu, e.alu); end
        n_checks++; if (exmem_flags !== e.flags) begin n_fail++; $display("FAIL add_flags: got %b expected %b", exmem_flags, e.flags); end
        n_checks++; if (exmem_jaddr !== 32'h22AF_37BC) begin n_fail++; $display("FAIL add_jaddr: got %h expected 22af37bc", exmem_jaddr); end
        n_checks++; if ({exmem_pc, exmem_mdata, exmem_waddr, exmem_wb} !== {32'h2000_0010, 32'h1, 5'd9, e.wb})
            begin n_fail++; $display("FAIL add_pass: got %h expected %h", {exmem_pc, exmem_mdata, exmem_waddr, exmem_wb}, {32'h2000_0010, 32'h1, 5'd9, e.wb}); end
    endtask

    task automatic test_sub_branch;
        exp_t e;
        set_op(OP_SUB, 32'd5, 32'd5, 16'h0001, 4'h2);
        idex_pc = 32'h0000_0100; idex_imm = 32'hFFFF_FFFE;
        sb_q.push_back('{32'h0, 4'b0101, 16'h0001, 4'h2});
        step;
        e = sb_q.pop_front();
        n_checks++; if (exmem_flags !== e.flags) begin n_fail++; $display("FAIL sub_flags: got %b expected %b", exmem_flags, e.flags); end
        n_checks++; if (exmem_baddr !== 32'h0000_00F8) begin n_fail++; $display("FAIL sub_baddr: got %h expected 000000f8", exmem_baddr); end
        n_checks++; if (exmem_m !== e.m) begin n_fail++; $display("FAIL sub_m: got %h expected %h", exmem_m, e.m); end
    endtask

    task automatic test_alu_ops;
        logic [4:0] ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd25};
        exp_t e; logic [31:0] a, b;
        for (int i = 0; i < 39; i++) begin
            a = (i < 13) ? 32'h8000_0000 : $urandom;
            b = (i < 13) ? 32'h0000_0001 : $urandom;
            set_op(ops[i % 13], a, b, 16'(i), 4'(i));
            idex_imm = $urandom; idex_alusrc = (i >= 26); idex_shamt = 5'($urandom_range(0, 31));
            sb_q.push_back(model(ops[i % 13], a, idex_alusrc ? idex_imm : b, idex_shamt, 16'(i), 4'(i)));
            step;
            e = sb_q.pop_front();
            n_checks++; if ({exmem_alu, exmem_flags, exmem_m, exmem_wb} !== {e.alu, e.flags, e.m, e.wb})
                begin n_fail++; $display("FAIL alu_op%0d: got %h/%b expected %h/%b", ops[i % 13], exmem_alu, exmem_flags, e.alu, e.flags); end
        end
        idex_alusrc = 1'b0; idex_shamt = 5'd0;
    endtask

    task automatic test_flush_bubble;
        set_op(OP_ADD, 32'd3, 32'd4, 16'hFFFF, 4'hF);
        flush = 1'b1;
        step;
        flush = 1'b0;
        n_checks++; if ({exmem_m, exmem_wb} !== 20'd0) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 0", {exmem_m, exmem_wb}); end
        n_checks++; if (exmem_alu !== 32'd7) begin n_fail++; $display("FAIL flush_alu: got %h expected 7", exmem_alu); end
    endtask

    task automatic test_mult;
        exp_t e; int n_stall; logic bubble_ok;
        set_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 16'h0004, 4'h5);
        sb_q.push_back('{32'h0, 4'b0001, 16'h0004, 4'h5});
        n_stall = 0; bubble_ok = 1'b1;
        #1;
        while (stall === 1'b1 && n_stall < 200) begin
            n_stall++;
            step;
            if ({exmem_m, exmem_wb} !== 20'd0) bubble_ok = 1'b0;
        end
        n_checks++; if (n_stall != MUL_STALL) begin n_fail++; $display("FAIL mult_stall_len: got %0d expected %0d", n_stall, MUL_STALL); end
        n_checks++; if (bubble_ok !== 1'b1) begin n_fail++; $display("FAIL mult_bubbles: got %b expected 1", bubble_ok); end
        step;
        e = sb_q.pop_front();
        n_checks++; if ({exmem_alu, exmem_flags, exmem_m, exmem_wb} !== {e.alu, e.flags, e.m, e.wb})
            begin n_fail++; $display("FAIL mult_load: got %h expected %h", {exmem_alu, exmem_flags, exmem_m, exmem_wb}, e); end
        set_op(OP_MFLO, 32'd0, 32'd0, 16'h0, 4'h1);
        step;
        n_checks++; if (exmem_alu !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", exmem_alu); end
        set_op(OP_MFHI, 32'd0, 32'd0, 16'h0, 4'h1);
        step;
        n_checks++; if (exmem_alu !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", exmem_alu); end
    endtask

    task automatic test_div;
        logic [4:0]  ops [4] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
        logic [31:0] as  [4] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'd16};
        logic [31:0] los [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF};
        logic [31:0] his [4] = '{32'd100, 32'hFFFF_FFFF, 32'd0, 32'd15};
        int n_stall;
        for (int i = 0; i < 4; i++) begin
            set_op(ops[i], as[i], bs[i], 16'h0010, 4'h3);
            n_stall = 0;
            #1;
            while (stall === 1'b1 && n_stall < 200) begin n_stall++; step; end
            n_checks++; if (n_stall != DIV_STALL) begin n_fail++; $display("FAIL div%0d_stall_len: got %0d expected %0d", i, n_stall, DIV_STALL); end
            step;
            n_checks++; if ({exmem_alu, exmem_m} !== {32'd0, 16'h0010}) begin n_fail++; $display("FAIL div%0d_load: got %h expected %h", i, {exmem_alu, exmem_m}, {32'd0, 16'h0010}); end
            set_op(OP_MFLO, 32'd0, 32'd0, 16'h0, 4'h1);
            step;
            n_checks++; if (exmem_alu !== los[i]) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, exmem_alu, los[i]); end
            set_op(OP_MFHI, 32'd0, 32'd0, 16'h0, 4'h1);
            step;
            n_checks++; if (exmem_alu !== his[i]) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, exmem_alu, his[i]); end
        end
    endtask

    task automatic test_div_flush;
        set_op(OP_MTHI, 32'h1111_2222, 32'd0, 16'h0, 4'h0); step;
        set_op(OP_MTLO, 32'h3333_4444, 32'd0, 16'h0, 4'h0); step;
        set_op(OP_DIV, 32'd100, 32'd7, 16'h00F0, 4'h3);
        for (int i = 0; i < 10; i++) step;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL dflush_busy: got %b expected 1", stall); end
        flush = 1'b1;
        set_op(OP_ADD, 32'd1, 32'd1, 16'h00F0, 4'h7);
        step;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL dflush_stall: got %b expected 0", stall); end
        n_checks++; if (exmem_wb !== 4'd0) begin n_fail++; $display("FAIL dflush_wb: got %h expected 0", exmem_wb); end
        set_op(OP_MTHI, 32'h0000_0BAD, 32'd0, 16'h0, 4'h0);
        step;
        flush = 1'b0;
        set_op(OP_MFHI, 32'd0, 32'd0, 16'h0, 4'h1); step;
        n_checks++; if (exmem_alu !== 32'h1111_2222) begin n_fail++; $display("FAIL dflush_hi: got %h expected 11112222", exmem_alu); end
        set_op(OP_MFLO, 32'd0, 32'd0, 16'h0, 4'h1); step;
        n_checks++; if (exmem_alu !== 32'h3333_4444) begin n_fail++; $display("FAIL dflush_lo: got %h expected 33334444", exmem_alu); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        set_op(OP_MULT, 32'd5, 32'd6, 16'h0001, 4'h1);
        idex_pc = 32'h0000_0200; idex_waddr = 5'd3;
        for (int i = 0; i < 5; i++) step;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", stall); end
        n_checks++; if (exmem_pc !== RST_PC) begin n_fail++; $display("FAIL rmid_pc: got %h expected %h", exmem_pc, RST_PC); end
        n_checks++; if ({exmem_alu, exmem_m, exmem_wb, exmem_flags, exmem_mdata, exmem_waddr} !== 93'd0)
            begin n_fail++; $display("FAIL rmid_fields: got %h expected 0", {exmem_alu, exmem_m, exmem_wb, exmem_flags, exmem_mdata, exmem_waddr}); end
        set_op(OP_ADD, 32'd2, 32'd3, 16'h0002, 4'h9);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{32'd5, 4'b0000, 16'h0002, 4'h9});
        step;
        e = sb_q.pop_front();
        n_checks++; if ({exmem_alu, exmem_flags, exmem_m, exmem_wb} !== {e.alu, e.flags, e.m, e.wb})
            begin n_fail++; $display("FAIL rmid_add: got %h expected %h", {exmem_alu, exmem_flags, exmem_m, exmem_wb}, e); end
        set_op(OP_MFHI, 32'd0, 32'd0, 16'h0, 4'h1); step;
        n_checks++; if (exmem_alu !== 32'd0) begin n_fail++; $display("FAIL rmid_hi: got %h expected 0", exmem_alu); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        idex_pc = 32'd0; idex_m = 16'd0; idex_wb = 4'd0; idex_aluop = OP_ADD; idex_alusrc = 1'b0;
        idex_rs = 32'd0; idex_rt = 32'd0; idex_imm = 32'd0; idex_shamt = 5'd0;
        idex_jfield = 26'd0; idex_waddr = 5'd0;
        test_reset();
        test_add_overflow();
        test_sub_branch();
        test_alu_ops();
        test_flush_bubble();
        test_mult();
        test_div();
        test_div_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
